// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM states and access-size decode for the load/store unit.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Any funct3 that is not a recognised byte/half code falls back to a word access.
    function automatic size_t access_size(input logic [2:0] f3, input logic load);
        if (load)
            return (f3 == F3_LB || f3 == F3_LBU) ? SZ_B :
                   (f3 == F3_LH || f3 == F3_LHU) ? SZ_H : SZ_W;
        return f3 == F3_SB ? SZ_B : f3 == F3_SH ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable and store-lane generation plus load-lane selection and extension.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [1:0]        offset,
    input  size_t             size,
    input  logic              sign,
    input  logic [DWIDTH-1:0] store_data,
    input  logic [DWIDTH-1:0] load_data,
    output logic [3:0]        be,
    output logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [1:0]        lane;
    logic [DWIDTH-1:0] shifted;

    always_comb begin
        lane    = size == SZ_B ? offset : size == SZ_H ? {offset[1], 1'b0} : 2'b00;
        be      = size == SZ_B ? 4'b0001 << lane :
                  size == SZ_H ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = size == SZ_B ? DWIDTH'({4{store_data[7:0]}}) :
                  size == SZ_H ? DWIDTH'({2{store_data[15:0]}}) : store_data;
        shifted = load_data >> {lane, 3'b000};
        rdata   = size == SZ_B ? {{(DWIDTH-8){sign & shifted[7]}}, shifted[7:0]} :
                  size == SZ_H ? {{(DWIDTH-16){sign & shifted[15]}}, shifted[15:0]} : shifted;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between execute stage and data memory.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of truncating the address.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DWIDTH-1:0] res_i,
    input  logic [DWIDTH-1:0] store_data_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic              done_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic              misalign_o
);

    state_t            state, next;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data, wb, ext, wdata;
    logic [3:0]        be;
    logic [2:0]        f3;
    logic              load, store, mem, misal, trap, in_load, in_store, accept;

    // Both class bits high is decoded as a load.
    assign in_load  = is_load_i;
    assign in_store = is_store_i & ~is_load_i;
    assign accept   = state == IDLE && valid_i;

`ifdef MISALIGN_TRAP_EN
    size_t in_size;
    assign in_size = access_size(funct3_i, in_load);
    assign trap    = (in_load | in_store) &
                     (in_size == SZ_H ? res_i[0] : in_size == SZ_W ? |res_i[1:0] : 1'b0);
`else
    assign trap = 1'b0;
`endif

    lsu_align #(.DWIDTH(DWIDTH)) u_align (
        .offset     (addr[1:0]),
        .size       (access_size(f3, load)),
        .sign       (~f3[2]),
        .store_data (data),
        .load_data  (dmem_rdata_i),
        .be         (be),
        .wdata      (wdata),
        .rdata      (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (valid_i) next = (in_load | in_store) & ~trap ? REQ : DONE;
            REQ:     if (dmem_gnt_i) next = load ? WAIT : DONE;
            WAIT:    if (dmem_rvalid_i) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            data  <= '0;
            f3    <= '0;
            load  <= 1'b0;
            store <= 1'b0;
            mem   <= 1'b0;
            misal <= 1'b0;
            wb    <= '0;
        end else if (accept) begin
            addr  <= AWIDTH'(res_i);
            data  <= store_data_i;
            f3    <= funct3_i;
            load  <= in_load;
            store <= in_store;
            mem   <= (in_load | in_store) & ~trap;
            misal <= trap;
            wb    <= (in_load | in_store) ? '0 : res_i;
        end else if (state == WAIT && dmem_rvalid_i) begin
            wb <= ext;
        end
    end

    // Memory-side outputs come from latched state so they stay stable while waiting for a grant.
    assign ready_o      = state == IDLE;
    assign dmem_req_o   = state == REQ;
    assign dmem_we_o    = state == REQ && store;
    assign dmem_addr_o  = mem ? {addr[AWIDTH-1:2], 2'b00} : '0;
    assign dmem_be_o    = mem ? be : 4'b0000;
    assign dmem_wdata_o = mem && store ? wdata : '0;
    assign done_o       = state == DONE;
    assign wb_data_o    = wb;
    assign misalign_o   = state == DONE && misal;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for spurious responses and reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, ready_o;
    logic [31:0] res_i = '0, store_data_i = '0;
    logic        is_load_i = 1'b0, is_store_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        done_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int checks = 0, errors = 0, cur = -1;

    typedef struct {
        logic ld, st; logic [2:0] f3;
        logic [31:0] res, sdata, rdata;
        int gdly, rdly;
        logic [31:0] addr; logic [3:0] be; logic [31:0] wdata, wb; logic mis;
    } vec_t;

    vec_t vecs[14];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .res_i(res_i), .store_data_i(store_data_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .funct3_i(funct3_i), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .done_o(done_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", cur, n, a, e);
        end
    endtask

    task automatic run(input vec_t v);
        logic mem;
        mem = (v.ld | v.st) & ~v.mis;
        @(negedge clk);
        chk("ready_idle", 32'(ready_o), 32'd1);
        valid_i = 1'b1; is_load_i = v.ld; is_store_i = v.st; funct3_i = v.f3;
        res_i = v.res; store_data_i = v.sdata;
        @(negedge clk);
        valid_i = 1'b0; res_i = 32'hFFFF_FFFF; store_data_i = 32'h5A5A_5A5A; funct3_i = 3'b111;
        if (mem) begin
            for (int i = 0; i <= v.gdly; i++) begin
                chk("req", 32'(dmem_req_o), 32'd1);
                chk("we", 32'(dmem_we_o), 32'(v.st & ~v.ld));
                chk("addr", dmem_addr_o, v.addr);
                chk("be", 32'(dmem_be_o), 32'(v.be));
                if (v.st & ~v.ld) chk("wdata", dmem_wdata_o, v.wdata);
                chk("done_early", 32'(done_o), 32'd0);
                if (i == v.gdly) dmem_gnt_i = 1'b1;
                @(negedge clk);
                dmem_gnt_i = 1'b0;
            end
            if (v.ld) begin
                for (int i = 0; i <= v.rdly; i++) begin
                    chk("wait_req", 32'(dmem_req_o), 32'd0);
                    chk("wait_done", 32'(done_o), 32'd0);
                    if (i == v.rdly) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata; end
                    @(negedge clk);
                    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
                end
            end
        end else begin
            chk("no_req", 32'(dmem_req_o), 32'd0);
        end
        chk("done", 32'(done_o), 32'd1);
        chk("misalign", 32'(misalign_o), 32'(v.mis));
        if (!(v.st & ~v.ld)) chk("wb", wb_data_o, v.wb);
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("ready_after", 32'(ready_o), 32'd1);
    endtask

    initial begin
        //          ld    st    f3      res           sdata         rdata        g  r  addr          be       wdata         wb            mis
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h0,       0, 0, 32'h100,      4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103,      32'h0,        32'h80123456,0, 0, 32'h100,      4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103,      32'h0,        32'h80123456,0, 0, 32'h100,      4'b1000, 32'h0,        32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h102,      32'h00001234, 32'h0,       3, 0, 32'h100,      4'b1100, 32'h12341234, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h200,      32'h0,        32'hCAFEF00D,0, 5, 32'h200,      4'b1111, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'b000, 32'h55AA1234, 32'h0,        32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h55AA1234, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h102,      32'h0,        32'h80017777,1, 2, 32'h100,      4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h100,      32'h0,        32'h12349ABC,0, 0, 32'h100,      4'b0011, 32'h0,        32'h00009ABC, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h101,      32'h123456A5, 32'h0,       0, 0, 32'h100,      4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b111, 32'h104,      32'h11223344, 32'h0,       0, 0, 32'h104,      4'b1111, 32'h11223344, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b100, 32'h101,      32'hFFFFFFFF, 32'h0000CD00,0, 0, 32'h100,      4'b0010, 32'h0,        32'h000000CD, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h100,      32'h0,        32'h0000007F,0, 0, 32'h100,      4'b0001, 32'h0,        32'h0000007F, 1'b0};
`ifdef MISALIGN_TRAP_EN
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h101,      32'h0,        32'h0BADBEEF,0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h103,      32'h0000BEEF, 32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
`else
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h101,      32'h0,        32'h0BADBEEF,0, 0, 32'h100,      4'b1111, 32'h0,        32'h0BADBEEF, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h103,      32'h0000BEEF, 32'h0,       0, 0, 32'h100,      4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0};
`endif
        #3;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_wb", wb_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cur = i;
            if (i == 4) begin
                // Stray grant and response while idle must not start or complete anything.
                @(negedge clk);
                dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
                repeat (2) begin
                    @(negedge clk);
                    chk("spur_done", 32'(done_o), 32'd0);
                    chk("spur_ready", 32'(ready_o), 32'd1);
                end
                dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rdata_i = 32'h0;
            end
            run(vecs[i]);
        end

        cur = 100;
        @(negedge clk);
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; res_i = 32'h300;
        @(negedge clk);
        valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("wait_ready", 32'(ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_req", 32'(dmem_req_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_wb", wb_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h13579BDF;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        chk("late_done", 32'(done_o), 32'd0);
        chk("late_wb", wb_data_o, 32'd0);
        chk("late_ready", 32'(ready_o), 32'd1);
        cur = 0;
        run(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DWIDTH, default 32, data width in bits.
REQ-002 Parameter AWIDTH, default 32, address width in bits.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  execute-stage result is present this cycle.
REQ-006 ready_o  output  1  the unit can accept an operation (high only in IDLE).
REQ-007 res_i  input  DWIDTH  ALU result: the effective address for loads and stores, or the pass-through value for all other operations.
REQ-008 store_data_i  input  DWIDTH  rs2 data to be stored.
REQ-009 is_load_i / is_store_i  input  1 each  operation class; both low means pass-through; both high is illegal and treated as a load.
REQ-010 funct3_i  input  3  access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 dmem_req_o  output  1  memory request.
REQ-012 dmem_we_o  output  1  request is a write.
REQ-013 dmem_addr_o  output  AWIDTH  word-aligned address, bits [1:0] = 0.
REQ-014 dmem_be_o  output  4  byte enables.
REQ-015 dmem_wdata_o  output  DWIDTH  store data, lane-shifted.
REQ-016 dmem_gnt_i  input  1  memory accepted the request.
REQ-017 dmem_rvalid_i / dmem_rdata_i  input  1 / DWIDTH  read response.
REQ-018 done_o  output  1  one-cycle completion pulse.
REQ-019 wb_data_o  output  DWIDTH  writeback value, valid while done_o is high.
REQ-020 misalign_o  output  1  completion was a misaligned-access fault (see REQ-036).

Function
REQ-021 The unit SHALL use the states IDLE, REQ, WAIT and DONE.
REQ-022 In IDLE, valid_i high SHALL latch all inputs; a load or store SHALL move to REQ, and a pass-through SHALL move to DONE with wb_data_o = res_i.
REQ-023 In REQ, dmem_req_o SHALL be 1 and every dmem output SHALL be held stable until dmem_gnt_i is high.
REQ-024 On a grant in REQ, a store SHALL move to DONE and a load SHALL move to WAIT.
REQ-025 In WAIT, dmem_rvalid_i SHALL capture the extended load data and move to DONE; with no rvalid the unit SHALL stay in WAIT indefinitely.
REQ-026 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-027 Minimum latency SHALL be: pass-through 1 cycle; store 2 cycles; load 3 cycles, counted from acceptance to done_o, with zero-wait grant and rvalid.
REQ-028 Byte lanes SHALL be: SB be = 1 << addr[1:0], data replicated across 4 bytes; SH be = 0011 or 1100 by addr[1], data replicated across 2 halves; SW be = 1111.
REQ-029 Loads SHALL select the byte or half by addr[1:0]; LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-030 An rvalid in any state other than WAIT, or a grant outside REQ, SHALL be ignored.
REQ-031 valid_i outside IDLE SHALL be ignored; upstream holds the operation until ready_o is high.
REQ-032 Undefined funct3 SHALL be treated as a word access.

Reset
REQ-033 Asserting rst_n low, at any time including mid-transaction, SHALL immediately force IDLE.
REQ-034 Reset values SHALL be: ready_o = 1; dmem_req_o, dmem_we_o, done_o and misalign_o = 0; dmem_addr_o, dmem_be_o, dmem_wdata_o and wb_data_o = 0.
REQ-035 A response still in flight at reset SHALL be dropped (covered by REQ-030).

Configuration
REQ-036 With MISALIGN_TRAP_EN defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL skip the request and go from IDLE directly to DONE with misalign_o = 1 and wb_data_o = 0.
REQ-037 Without MISALIGN_TRAP_EN, the low address bits SHALL be truncated to the natural alignment, the access SHALL proceed, and misalign_o SHALL be tied to 0.

Structure
REQ-038 The FUNCT3 load/store constants and the state enum SHALL live in the shared constants package.
REQ-039 Lane alignment and extension SHALL be a combinational sub-module named lsu_align.

Verification
REQ-040 SW, res_i = 0x100, data 0xDEADBEEF, grant immediate -> addr 0x100, be 1111, done_o 2 cycles after acceptance.
REQ-041 LB at 0x103, rdata 0x80xxxxxx -> wb_data_o = 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-042 SH at 0x102, data 0x1234 -> be 1100, wdata 0x12341234; grant delayed 3 cycles -> all dmem outputs stable throughout.
REQ-043 LW with rvalid delayed 5 cycles, plus a spurious rvalid in IDLE -> single done_o, data taken from the WAIT response only.
REQ-044 rst_n pulled low while in WAIT -> IDLE immediately, ready_o = 1, late rvalid ignored.
REQ-045 LW at 0x101 with MISALIGN_TRAP_EN -> no dmem_req_o, misalign_o = 1 with done_o 1 cycle after acceptance; without the macro -> access to 0x100.
